pipeline_stall_ctrl: RTL and testbench

Central stall, flush and halt sequencer for the 5-stage pipeline (PC → IF_ID → ID_Ex → EX_MEM → MEM_WB).
- Owns the PC write-enable and the four pipeline-register enables, replacing the fixed enables from the control unit.
- Interlocks RAW hazards, since the datapath has no forwarding.
- Squashes wrong-path instructions on a taken branch.
- Freezes the pipeline while data memory is busy.
- Drains and halts the machine on a halt instruction.
- Keeps saturating stall/flush counters for debug.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 11 +
 rtl/sat_counter.sv | 17 +
 rtl/pipeline_stall_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush/halt sequencer.
package pipeline_stall_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int DRAIN_CYCLES   = 3;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (Reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush/halt sequencer for the 5-stage pipeline: RAW interlock,
// branch squash, memory-busy freeze, halt drain and debug counters.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
    parameter int CNT_W        = 16,
    parameter int HARDWIRED_R0 = 1
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  IdValid,
    input  logic [REG_ADDR_W-1:0] ReadAddr1,
    input  logic [REG_ADDR_W-1:0] ReadAddr2,
    input  logic                  ReadUse1,
    input  logic                  ReadUse2,
    input  logic [REG_ADDR_W-1:0] ExRd,
    input  logic [REG_ADDR_W-1:0] MemRd,
    input  logic [REG_ADDR_W-1:0] WbRd,
    input  logic                  ExRegWrite,
    input  logic                  MemRegWrite,
    input  logic                  WbRegWrite,
    input  logic                  BranchTaken,
    input  logic                  MemBusy,
    input  logic                  Halt,
    output logic                  PCEnable,
    output logic                  Enable1,
    output logic                  Enable2,
    output logic                  Enable3,
    output logic                  Enable4,
    output logic                  Flush1,
    output logic                  Flush2,
    output logic                  Halted,
    output logic [CNT_W-1:0]      StallCount,
    output logic [CNT_W-1:0]      FlushCount,
    output logic [1:0]            State
);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    state_t        state, state_nxt;
    logic [DW-1:0] drain_cnt, drain_nxt;
    logic [3:0]    en;
    logic          flush1_raw, flush2_raw;
    logic          stall_inc, flush_inc;
    logic          match1, match2, hazard;

    // No forwarding: a pending write in EX, MEM or WB blocks the reader.
    function automatic logic reg_match(
        input logic [REG_ADDR_W-1:0] a,
        input logic [REG_ADDR_W-1:0] ex_rd,
        input logic [REG_ADDR_W-1:0] mem_rd,
        input logic [REG_ADDR_W-1:0] wb_rd,
        input logic                  ex_w,
        input logic                  mem_w,
        input logic                  wb_w
    );
        logic m;
        m = (ex_w && (ex_rd == a)) || (mem_w && (mem_rd == a)) || (wb_w && (wb_rd == a));
        if ((HARDWIRED_R0 != 0) && (a == '0)) begin
            m = 1'b0;
        end
        return m;
    endfunction

    assign match1 = reg_match(ReadAddr1, ExRd, MemRd, WbRd, ExRegWrite, MemRegWrite, WbRegWrite);
    assign match2 = reg_match(ReadAddr2, ExRd, MemRd, WbRd, ExRegWrite, MemRegWrite, WbRegWrite);
    assign hazard = IdValid && ((ReadUse1 && match1) || (ReadUse2 && match2));

    always_ff @(posedge clk) begin
        if (Reset) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        drain_nxt  = drain_cnt;
        PCEnable   = 1'b0;
        en         = 4'b0000;
        flush1_raw = 1'b0;
        flush2_raw = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (MemBusy) begin
                    stall_inc = 1'b1;
                end else if (BranchTaken) begin
                    PCEnable   = 1'b1;
                    en         = 4'b1111;
                    flush1_raw = 1'b1;
                    flush2_raw = 1'b1;
                    flush_inc  = 1'b1;
                end else if (hazard) begin
                    en         = 4'b1110;
                    flush2_raw = 1'b1;
                    stall_inc  = 1'b1;
                end else if (Halt) begin
                    // The halt itself becomes a bubble; older work drains behind it.
                    en         = 4'b1110;
                    flush2_raw = 1'b1;
                    state_nxt  = ST_DRAIN;
                    drain_nxt  = DW'(DRAIN_CYCLES);
                end else begin
                    PCEnable = 1'b1;
                    en       = 4'b1111;
                end
            end
            ST_DRAIN: begin
                if (MemBusy) begin
                    stall_inc = 1'b1;
                end else begin
                    en         = 4'b1110;
                    flush2_raw = 1'b1;
                    drain_nxt  = drain_cnt - DW'(1);
                    if (drain_cnt == DW'(1)) begin
                        state_nxt = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    assign Enable1 = en[0];
    assign Enable2 = en[1];
    assign Enable3 = en[2];
    assign Enable4 = en[3];
    assign Flush1  = flush1_raw && !Reset;
    assign Flush2  = flush2_raw && !Reset;
    assign Halted  = (state == ST_HALTED);
    assign State   = state;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .Reset (Reset),
        .inc   (stall_inc),
        .count (StallCount)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .Reset (Reset),
        .inc   (flush_inc),
        .count (FlushCount)
    );
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: default build plus a CNT_W=4 /
// HARDWIRED_R0=0 build driven by the same stimulus.
module tb_pipeline_stall_ctrl;
    logic       clk = 1'b0;
    logic       rst, idv, ru1, ru2, exw, memw, wbw, br, busy, halt;
    logic [4:0] ra1, ra2, exrd, memrd, wbrd;

    logic        pce [2];
    logic        e1 [2];
    logic        e2 [2];
    logic        e3 [2];
    logic        e4 [2];
    logic        f1 [2];
    logic        f2 [2];
    logic        hlt [2];
    logic [1:0]  st [2];
    logic [15:0] sc0, fc0;
    logic [3:0]  sc1, fc1;

    typedef struct {
        int pce; int en; int f1; int f2; int hlt; int st; int sc; int fc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ms[2], md[2], msc[2], mfc[2];
    int   ns_t[2], nd_t[2], nsc_t[2], nfc_t[2];

    always #5 clk = ~clk;

    pipeline_stall_ctrl dut (
        .clk(clk), .Reset(rst), .IdValid(idv), .ReadAddr1(ra1), .ReadAddr2(ra2),
        .ReadUse1(ru1), .ReadUse2(ru2), .ExRd(exrd), .MemRd(memrd), .WbRd(wbrd),
        .ExRegWrite(exw), .MemRegWrite(memw), .WbRegWrite(wbw), .BranchTaken(br),
        .MemBusy(busy), .Halt(halt), .PCEnable(pce[0]), .Enable1(e1[0]),
        .Enable2(e2[0]), .Enable3(e3[0]), .Enable4(e4[0]), .Flush1(f1[0]),
        .Flush2(f2[0]), .Halted(hlt[0]), .StallCount(sc0), .FlushCount(fc0),
        .State(st[0])
    );

    pipeline_stall_ctrl #(.REG_ADDR_W(5), .CNT_W(4), .HARDWIRED_R0(0)) dut_small (
        .clk(clk), .Reset(rst), .IdValid(idv), .ReadAddr1(ra1), .ReadAddr2(ra2),
        .ReadUse1(ru1), .ReadUse2(ru2), .ExRd(exrd), .MemRd(memrd), .WbRd(wbrd),
        .ExRegWrite(exw), .MemRegWrite(memw), .WbRegWrite(wbw), .BranchTaken(br),
        .MemBusy(busy), .Halt(halt), .PCEnable(pce[1]), .Enable1(e1[1]),
        .Enable2(e2[1]), .Enable3(e3[1]), .Enable4(e4[1]), .Flush1(f1[1]),
        .Flush2(f2[1]), .Halted(hlt[1]), .StallCount(sc1), .FlushCount(fc1),
        .State(st[1])
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit mdl_match(input int i, input int a);
        if (a == 0 && i == 0) return 1'b0;
        return (exw && int'(exrd) == a) || (memw && int'(memrd) == a) || (wbw && int'(wbrd) == a);
    endfunction

    // Reference behaviour: expected outputs this cycle and the state after the edge.
    task automatic model(input int i, output exp_t e);
        bit hz, sinc, finc;
        int cmax;
        cmax = (i == 0) ? 65535 : 15;
        hz   = idv && ((ru1 && mdl_match(i, int'(ra1))) || (ru2 && mdl_match(i, int'(ra2))));
        sinc = 0; finc = 0;
        e = '{pce: 0, en: 0, f1: 0, f2: 0, hlt: 0, st: ms[i], sc: msc[i], fc: mfc[i]};
        ns_t[i] = ms[i]; nd_t[i] = md[i];
        if (ms[i] == 0) begin
            if (busy) sinc = 1;
            else if (br) begin e.pce = 1; e.en = 15; e.f1 = 1; e.f2 = 1; finc = 1; end
            else if (hz) begin e.en = 14; e.f2 = 1; sinc = 1; end
            else if (halt) begin e.en = 14; e.f2 = 1; ns_t[i] = 1; nd_t[i] = 3; end
            else begin e.pce = 1; e.en = 15; end
        end else if (ms[i] == 1) begin
            if (busy) sinc = 1;
            else begin
                e.en = 14; e.f2 = 1; nd_t[i] = md[i] - 1;
                if (md[i] == 1) ns_t[i] = 2;
            end
        end else begin
            e.hlt = 1;
        end
        nsc_t[i] = (sinc && msc[i] < cmax) ? msc[i] + 1 : msc[i];
        nfc_t[i] = (finc && mfc[i] < cmax) ? mfc[i] + 1 : mfc[i];
        if (rst) begin
            e.f1 = 0; e.f2 = 0;
            ns_t[i] = 0; nd_t[i] = 0; nsc_t[i] = 0; nfc_t[i] = 0;
        end
    endtask

    function automatic exp_t observe(input int i);
        exp_t o;
        o.pce = int'(pce[i]);
        o.en  = int'({e4[i], e3[i], e2[i], e1[i]});
        o.f1  = int'(f1[i]);
        o.f2  = int'(f2[i]);
        o.hlt = int'(hlt[i]);
        o.st  = int'(st[i]);
        o.sc  = (i == 0) ? int'(sc0) : int'(sc1);
        o.fc  = (i == 0) ? int'(fc0) : int'(fc1);
        return o;
    endfunction

    task automatic step();
        exp_t e, x, o;
        for (int i = 0; i < 2; i++) begin
            model(i, e);
            sb.push_back(e);
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            x = sb.pop_front();
            o = observe(i);
            chk($sformatf("d%0d.PCEnable", i), o.pce, x.pce);
            chk($sformatf("d%0d.Enable4..1", i), o.en, x.en);
            chk($sformatf("d%0d.Flush1", i), o.f1, x.f1);
            chk($sformatf("d%0d.Flush2", i), o.f2, x.f2);
            chk($sformatf("d%0d.Halted", i), o.hlt, x.hlt);
            chk($sformatf("d%0d.State", i), o.st, x.st);
            chk($sformatf("d%0d.StallCount", i), o.sc, x.sc);
            chk($sformatf("d%0d.FlushCount", i), o.fc, x.fc);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            ms[i] = ns_t[i]; md[i] = nd_t[i]; msc[i] = nsc_t[i]; mfc[i] = nfc_t[i];
        end
        #1;
    endtask

    task automatic idle();
        rst = 0; idv = 0; ru1 = 0; ru2 = 0; exw = 0; memw = 0; wbw = 0;
        br = 0; busy = 0; halt = 0;
        ra1 = '0; ra2 = '0; exrd = '0; memrd = '0; wbrd = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 2; i++) begin ms[i] = 0; md[i] = 0; msc[i] = 0; mfc[i] = 0; end

        // Reset state, then normal flow
        step();
        step();

        // RAW hazard against producer moving EX -> MEM -> WB -> gone
        idv = 1; ru1 = 1; ra1 = 5'd3; exrd = 5'd3; exw = 1;
        step();
        exw = 0; memrd = 5'd3; memw = 1;
        step();
        memw = 0; wbrd = 5'd3; wbw = 1;
        step();
        wbw = 0;
        step();
        // Second read port
        ru1 = 0; ru2 = 1; ra2 = 5'd7; memrd = 5'd7; memw = 1;
        step();
        idle();

        // Register 0: no hazard when hardwired, hazard otherwise
        idv = 1; ru1 = 1; ra1 = 5'd0; exrd = 5'd0; exw = 1;
        step();
        idle();
        step();

        // Branch beats hazard and halt
        idv = 1; ru1 = 1; ra1 = 5'd3; exrd = 5'd3; exw = 1; halt = 1; br = 1;
        step();
        idle();
        step();

        // Busy freeze with branch pending, then branch applies
        br = 1; busy = 1;
        repeat (4) step();
        busy = 0;
        step();
        idle();
        step();

        // Halt drain, ignored inputs while halted, reset out
        halt = 1; step();
        halt = 0; repeat (3) step();
        step();
        br = 1; idv = 1; ru1 = 1; ra1 = 5'd2; exrd = 5'd2; exw = 1; halt = 1;
        step();
        idle(); rst = 1; step();
        rst = 0; step();

        // Halt drain interrupted by busy
        halt = 1; step();
        halt = 0; step();
        busy = 1; repeat (2) step();
        busy = 0; repeat (2) step();
        step();
        idle(); rst = 1; step();
        rst = 0; step();

        // Reset in the middle of the drain
        halt = 1; step();
        halt = 0; step();
        rst = 1; step();
        rst = 0; step();
        step();

        // Counter saturation on the 4-bit build
        idv = 1; ru1 = 1; ra1 = 5'd5; exrd = 5'd5; exw = 1;
        repeat (20) step();
        idle(); step();

        // Randomised traffic
        for (int n = 0; n < 60; n++) begin
            rst   = ($urandom_range(0, 15) == 0);
            idv   = $urandom_range(0, 1);
            ru1   = $urandom_range(0, 1);
            ru2   = $urandom_range(0, 1);
            ra1   = 5'($urandom_range(0, 3));
            ra2   = 5'($urandom_range(0, 3));
            exrd  = 5'($urandom_range(0, 3));
            memrd = 5'($urandom_range(0, 3));
            wbrd  = 5'($urandom_range(0, 3));
            exw   = $urandom_range(0, 1);
            memw  = $urandom_range(0, 1);
            wbw   = $urandom_range(0, 1);
            br    = ($urandom_range(0, 5) == 0);
            busy  = ($urandom_range(0, 3) == 0);
            halt  = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
